// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer APB driver: FSM state codes, default
// register addresses and the result-ready bit position in the poll word.
package eq_pkg;

   typedef logic [2:0] eq_state_t;

   localparam eq_state_t StIdle     = 3'd0;
   localparam eq_state_t StWrSetup  = 3'd1;
   localparam eq_state_t StWrAccess = 3'd2;
   localparam eq_state_t StRdSetup  = 3'd3;
   localparam eq_state_t StRdAccess = 3'd4;
   localparam eq_state_t StOutHold  = 3'd5;

   localparam logic [31:0] EqWrAddrDefault   = 32'h0000_0EB0;
   localparam logic [31:0] EqPollAddrDefault = 32'h0000_0EB0;

   localparam int unsigned EqReadyBit = 31;

endpackage

// File: rtl/eq_poll_counter.sv
// Counts not-ready poll reads for the current sample and flags the last
// permitted poll so the driver can give up on the following miss.
module eq_poll_counter #(
   parameter int unsigned POLL_LIMIT = 255,
   localparam int unsigned CntW = $clog2(POLL_LIMIT + 1)
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Clear,
   input  logic Incr,
   output logic TermCnt
);

   logic [CntW-1:0] count_q;

   // Clear wins over increment so a sample accept always starts from zero.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
      end else if (Clear) begin
         count_q <= '0;
      end else if (Incr) begin
         count_q <= count_q + CntW'(1);
      end
   end

   // Terminal when the current read is the last one allowed.
   always_comb begin
      TermCnt = (count_q == CntW'(POLL_LIMIT - 1));
   end

endmodule

// File: rtl/eq_apb_driver.sv
// Streams audio samples to the equalizer over APB: one broadcast write per
// sample, then polls the result register until ready or the poll budget runs out.
module eq_apb_driver import eq_pkg::*; #(
   parameter logic [31:0] WR_ADDR    = EqWrAddrDefault,
   parameter logic [31:0] POLL_ADDR  = EqPollAddrDefault,
   parameter int unsigned POLL_LIMIT = 255
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [15:0] InSample,
   output logic        PSel,
   output logic        PEnable,
   output logic        PWrite,
   output logic [31:0] PAddr,
   output logic [31:0] PWData,
   input  logic [31:0] PRData,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [15:0] OutSample,
   output logic        TimeoutErr,
   output logic        Busy
);

   eq_state_t   state_q, state_d;
   logic [15:0] sample_q;
   logic [15:0] out_sample_q;
   logic        timeout_q;

   logic accept;
   logic rd_done;
   logic rd_ready;
   logic rd_miss;
   logic poll_term;
   logic unused_prdata;

   assign accept        = InValid & (state_q == StIdle);
   assign rd_done       = (state_q == StRdAccess);
   assign rd_ready      = PRData[EqReadyBit];
   assign rd_miss       = rd_done & ~rd_ready;
   assign unused_prdata = ^PRData[30:16];

   eq_poll_counter #(
      .POLL_LIMIT (POLL_LIMIT)
   ) u_poll_counter (
      .Clk     (Clk),
      .Reset   (Reset),
      .Clear   (accept | (rd_miss & poll_term)),
      .Incr    (rd_miss & ~poll_term),
      .TermCnt (poll_term)
   );

   // Next-state selection; every APB phase lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:     if (InValid) state_d = StWrSetup;
         StWrSetup:  state_d = StWrAccess;
         StWrAccess: state_d = StRdSetup;
         StRdSetup:  state_d = StRdAccess;
         StRdAccess: begin
            if (rd_ready)       state_d = StOutHold;
            else if (poll_term) state_d = StIdle;
            else                state_d = StRdSetup;
         end
         StOutHold:  if (OutReady) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // State, captured sample, result register and timeout pulse.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= StIdle;
         sample_q     <= '0;
         out_sample_q <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= rd_miss & poll_term;
         if (accept) begin
            sample_q <= InSample;
         end
         if (rd_done && rd_ready) begin
            out_sample_q <= PRData[15:0];
         end
      end
   end

   // APB and stream outputs decoded from the registered state only.
   always_comb begin
      PSel     = 1'b0;
      PEnable  = 1'b0;
      PWrite   = 1'b0;
      PAddr    = '0;
      PWData   = '0;
      InReady  = 1'b0;
      OutValid = 1'b0;
      case (state_q)
         StIdle: InReady = 1'b1;
         StWrSetup, StWrAccess: begin
            PSel    = 1'b1;
            PEnable = (state_q == StWrAccess);
            PWrite  = 1'b1;
            PAddr   = WR_ADDR;
            PWData  = {16'h0000, sample_q};
         end
         StRdSetup, StRdAccess: begin
            PSel    = 1'b1;
            PEnable = (state_q == StRdAccess);
            PAddr   = POLL_ADDR;
         end
         StOutHold: OutValid = 1'b1;
         default: ;
      endcase
   end

   assign OutSample  = out_sample_q;
   assign TimeoutErr = timeout_q;
   assign Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_eq_apb_driver.sv
// Randomized bench for eq_apb_driver: an APB slave model answers polls after a
// chosen number of misses, and a per-sample reference predicts reads, latency,
// output value and timeouts from the transaction rules.
module tb_eq_apb_driver;

   localparam int unsigned PollLimit = 4;
   localparam logic [31:0] EqAddr    = 32'h0000_0EB0;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [15:0] InSample;
   logic        PSel;
   logic        PEnable;
   logic        PWrite;
   logic [31:0] PAddr;
   logic [31:0] PWData;
   logic [31:0] PRData;
   logic        OutValid;
   logic        OutReady;
   logic [15:0] OutSample;
   logic        TimeoutErr;
   logic        Busy;

   always #5 Clk = ~Clk;

   eq_apb_driver #(
      .WR_ADDR    (32'h0000_0EB0),
      .POLL_ADDR  (32'h0000_0EB0),
      .POLL_LIMIT (PollLimit)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .InValid    (InValid),
      .InReady    (InReady),
      .InSample   (InSample),
      .PSel       (PSel),
      .PEnable    (PEnable),
      .PWrite     (PWrite),
      .PAddr      (PAddr),
      .PWData     (PWData),
      .PRData     (PRData),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .OutSample  (OutSample),
      .TimeoutErr (TimeoutErr),
      .Busy       (Busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // APB slave model: the poll word becomes ready once ready_after misses were served.
   int          poll_idx = 0;
   int          ready_after;
   logic [15:0] result_v;
   logic [14:0] hi_v;
   logic [30:0] garbage;

   always @(posedge Clk) begin
      if (InValid && InReady) poll_idx <= 0;
      else if (PSel && PEnable && !PWrite) poll_idx <= poll_idx + 1;
   end

   always_comb begin
      if (poll_idx >= ready_after) PRData = {1'b1, hi_v, result_v};
      else PRData = {1'b0, garbage};
   end

   // Bus monitor: protocol rules on every cycle, transfer and pulse counters.
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          to_cnt = 0;
   logic [31:0] last_wdata = '0;
   logic [31:0] last_waddr = '0;
   logic        prev_setup = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [31:0] prev_wdata = '0;
   logic        prev_write = 1'b0;

   always @(negedge Clk) begin
      if (Reset) begin
         prev_setup = 1'b0;
      end else begin
         if (PEnable) check_eq("penable_needs_psel", 32'(PSel), 32'h1);
         if (!PSel) check_eq("idle_bus_zero", PAddr | PWData | 32'({PWrite, PEnable}), 32'h0);
         if (PSel && PEnable) begin
            check_eq("access_after_setup", 32'(prev_setup), 32'h1);
            check_eq("access_addr_stable", PAddr, prev_addr);
            check_eq("access_wdata_stable", PWData, prev_wdata);
            check_eq("access_dir_stable", 32'(PWrite), 32'(prev_write));
            if (PWrite) begin
               wr_cnt++;
               last_wdata = PWData;
               last_waddr = PAddr;
            end else begin
               rd_cnt++;
               check_eq("poll_addr", PAddr, EqAddr);
            end
         end
         if (TimeoutErr) to_cnt++;
         prev_setup = PSel & ~PEnable;
         prev_addr  = PAddr;
         prev_wdata = PWData;
         prev_write = PWrite;
      end
   end

   // One sample through the driver; n_nr = polls answered not-ready before ready.
   task automatic run_sample(input logic [15:0] smp, input int n_nr, input logic [15:0] res,
                             input logic [14:0] hi, input int hold);
      int wr0, rd0, to0, cyc, exp_reads;
      bit to_exp;
      to_exp      = (n_nr >= int'(PollLimit));
      exp_reads   = to_exp ? int'(PollLimit) : n_nr + 1;
      ready_after = n_nr;
      result_v    = res;
      hi_v        = hi;
      garbage     = 31'($urandom);
      @(negedge Clk);
      InValid  = 1'b1;
      InSample = smp;
      OutReady = 1'b0;
      cyc = 0;
      while (!InReady && cyc < 50) begin
         @(negedge Clk);
         cyc++;
      end
      check_eq("in_ready_wait", 32'(InReady), 32'h1);
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      to0 = to_cnt;
      @(posedge Clk);
      #1;
      InValid  = 1'b0;
      InSample = 16'($urandom);
      cyc = 0;
      if (!to_exp) begin
         do begin
            @(negedge Clk);
            cyc++;
         end while (!OutValid && cyc < 60);
         check_eq("out_latency", 32'(cyc), 32'(5 + 2 * n_nr));
         check_eq("out_sample", 32'(OutSample), 32'(res));
         for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check_eq("hold_sample", 32'(OutSample), 32'(res));
            check_eq("hold_stall", 32'({InReady, PSel, OutValid, Busy}), 32'h3);
         end
         OutReady = 1'b1;
         @(negedge Clk);
         check_eq("after_handshake", 32'({InReady, OutValid, Busy}), 32'h4);
         OutReady = 1'b0;
      end else begin
         do begin
            @(negedge Clk);
            cyc++;
         end while (!TimeoutErr && cyc < 60);
         check_eq("timeout_latency", 32'(cyc), 32'(3 + 2 * PollLimit));
         check_eq("timeout_idle", 32'({InReady, OutValid, PSel, Busy}), 32'h8);
         @(negedge Clk);
         check_eq("timeout_one_cycle", 32'(TimeoutErr), 32'h0);
      end
      @(posedge Clk);
      #1;
      check_eq("n_writes", 32'(wr_cnt - wr0), 32'h1);
      check_eq("write_data", last_wdata, {16'h0000, smp});
      check_eq("write_addr", last_waddr, EqAddr);
      check_eq("n_reads", 32'(rd_cnt - rd0), 32'(exp_reads));
      check_eq("n_timeouts", 32'(to_cnt - to0), 32'(to_exp));
   endtask

   // Reset during the write access phase, then reset racing an accept.
   task automatic reset_mid_write();
      int seen;
      ready_after = 0;
      result_v    = 16'hDEAD;
      @(negedge Clk);
      InValid  = 1'b1;
      InSample = 16'h5555;
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      @(negedge Clk);
      check_eq("rst_wr_setup", 32'({PSel, PEnable, PWrite}), 32'h5);
      @(negedge Clk);
      check_eq("rst_wr_access", 32'({PSel, PEnable, PWrite}), 32'h7);
      Reset = 1'b1;
      @(negedge Clk);
      check_eq("rst_abort", 32'({PSel, PEnable, InReady, OutValid, Busy}), 32'h4);
      check_eq("rst_out_sample", 32'(OutSample), 32'h0);
      InValid = 1'b1;
      @(negedge Clk);
      check_eq("rst_beats_accept", 32'({PSel, InReady, Busy}), 32'h2);
      Reset   = 1'b0;
      InValid = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge Clk);
         if (OutValid || PSel) seen++;
      end
      check_eq("rst_no_activity", 32'(seen), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      Reset       = 1'b1;
      InValid     = 1'b0;
      InSample    = '0;
      OutReady    = 1'b0;
      ready_after = 0;
      result_v    = '0;
      hi_v        = '0;
      garbage     = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check_eq("reset_ctrl", 32'({InReady, PSel, PEnable, PWrite, OutValid, TimeoutErr, Busy}),
               32'h40);
      check_eq("reset_bus", PAddr | PWData, 32'h0);
      check_eq("reset_out_sample", 32'(OutSample), 32'h0);
      Reset = 1'b0;

      run_sample(16'h1234, 0, 16'h0ABC, 15'h0, 0);
      run_sample(16'h0042, 2, 16'hBEEF, 15'h0, 1);
      run_sample(16'h0F0F, 6, 16'h1111, 15'h0, 0);
      run_sample(16'hA5A5, 1, 16'h3C3C, 15'h0, 10);
      reset_mid_write();
      run_sample(16'h7FFF, 0, 16'h7FFE, 15'h0, 0);
      run_sample(16'h8000, 1, 16'h8001, 15'h0, 0);

      for (int i = 0; i < 20; i++) begin
         run_sample(16'($urandom), int'($urandom_range(0, 5)), 16'($urandom), 15'($urandom),
                    int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/eq_apb_driver.md
EQ_APB_DRIVER -- requirements
Module: eq_apb_driver

Interface
REQ-001 SHALL have parameter WR_ADDR, default 32'h0000_0EB0, the APB address for sample writes (broadcast to all bands).
REQ-002 SHALL have parameter POLL_ADDR, default 32'h0000_0EB0, the APB address read to poll result/ready.
REQ-003 SHALL have parameter POLL_LIMIT, default 255, the maximum number of poll reads per sample before timeout.
REQ-004 SHALL have port Clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port InValid, input, 1, the upstream sample valid.
REQ-007 SHALL have port InReady, output, 1, the upstream sample ready.
REQ-008 SHALL have port InSample, input, 16, the signed input audio sample.
REQ-009 SHALL have port PSel, output, 1, the APB select.
REQ-010 SHALL have port PEnable, output, 1, the APB enable (access phase).
REQ-011 SHALL have port PWrite, output, 1, the APB direction (1 = write).
REQ-012 SHALL have port PAddr, output, 32, the APB address.
REQ-013 SHALL have port PWData, output, 32, the APB write data.
REQ-014 SHALL have port PRData, input, 32, the APB read data; bit 31 = result ready, bits 15:0 = summed sample.
REQ-015 SHALL have port OutValid, output, 1, the equalized sample valid.
REQ-016 SHALL have port OutReady, input, 1, the downstream ready.
REQ-017 SHALL have port OutSample, output, 16, the equalized sample.
REQ-018 SHALL have port TimeoutErr, output, 1, a one-cycle pulse when polling exhausts POLL_LIMIT.
REQ-019 SHALL have port Busy, output, 1, high whenever state is not IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, OUT_HOLD.
REQ-021 SHALL assert InReady only in IDLE; a transfer occurs on InValid&InReady, capturing InSample and moving to WR_SETUP.
REQ-022 SHALL drive in WR_SETUP: PSel=1, PEnable=0, PWrite=1, PAddr=WR_ADDR, PWData={16'h0, sample}; next state is WR_ACCESS.
REQ-023 SHALL in WR_ACCESS keep the same signals with PEnable=1; next state is RD_SETUP; there is no wait state (no PREADY).
REQ-024 SHALL drive in RD_SETUP: PSel=1, PEnable=0, PWrite=0, PAddr=POLL_ADDR, PWData=0; next state is RD_ACCESS.
REQ-025 SHALL sample PRData at the end of RD_ACCESS (PEnable=1); if PRData[31]=1, register OutSample=PRData[15:0] and go to OUT_HOLD; otherwise increment the poll count and go to RD_SETUP.
REQ-026 SHALL, when a not-ready read occurs with poll count = POLL_LIMIT-1, pulse TimeoutErr for one cycle, clear the count, and return to IDLE with no output.
REQ-027 SHALL clear the poll count on every sample accept.
REQ-028 SHALL have minimum latency: accept at edge k → write phases in cycles k+1, k+2 → read phases in k+3, k+4 → OutValid high from cycle k+5.
REQ-029 SHALL hold OutValid and OutSample stable in OUT_HOLD until OutValid&OutReady, then go to IDLE; back-pressure stalls indefinitely.
REQ-030 SHALL drive PSel/PEnable/PWrite low and PAddr/PWData at zero outside APB phases.
REQ-031 SHALL never assert PEnable without PSel, and SHALL never change PAddr/PWrite/PWData between the setup and access phases.

Reset
REQ-032 SHALL on Reset force state IDLE, poll count 0, OutSample 0, with all outputs 0 except InReady=1 in the cycle after reset.
REQ-033 SHALL abort an in-flight APB transfer immediately when Reset is asserted mid-transfer; PSel SHALL be 0 in the next cycle.
REQ-034 SHALL take Reset priority over every other event, including a simultaneous input accept.

Structure
REQ-035 SHALL place the state enum, the default WR_ADDR/POLL_ADDR constants, and the ready-bit index (31) in shared package eq_pkg.
REQ-036 SHALL place the poll counter with terminal-count flag in a single sub-module, eq_poll_counter, of width $clog2(POLL_LIMIT+1).

Verification
REQ-037 SHALL cover: InSample=16'h1234 with the model returning ready on the first poll with PRData=32'h8000_0ABC → one write of 32'h0000_1234 to 0xEB0, OutSample=16'h0ABC, OutValid at k+5.
REQ-038 SHALL cover: the model returns ready on the 3rd poll → exactly 3 read transfers, OutValid at k+9.
REQ-039 SHALL cover: POLL_LIMIT=4 with the model never ready → 4 reads, a single TimeoutErr pulse, return to IDLE, InReady=1.
REQ-040 SHALL cover: OutReady held low for 10 cycles → OutSample stable, InReady=0 throughout, and no APB activity.
REQ-041 SHALL cover: Reset asserted during WR_ACCESS → PSel=0 the next cycle, InReady=1, and no OutValid.
REQ-042 SHALL cover: back-to-back samples 16'h7FFF then 16'h8000 → two complete write/poll sequences in order, with the APB protocol assertions (REQ-031) passing throughout.
